// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the key debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    REL_STABLE  = 2'd0,
    PRESS_CHECK = 2'd1,
    PRS_STABLE  = 2'd2,
    REL_CHECK   = 2'd3
  } deb_state_t;

  // Width needed to hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: two-flop synchroniser, polarity normalise, stability FSM.
//
// state       | meaning
// REL_STABLE  | key released and stable; waiting for a press level
// PRESS_CHECK | press level seen; counting consecutive press samples
// PRS_STABLE  | key pressed and stable; waiting for a release level
// REL_CHECK   | release level seen; counting consecutive release samples
module key_debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_raw_i,
  output logic key_o,
  output logic key_press_o,
  output logic key_release_o
);

  localparam int              CW   = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  logic          lvl;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // Synchroniser resets to the raw level of a released key.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= ACTIVE_LOW_IN;
      sync2_q <= ACTIVE_LOW_IN;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign lvl = sync2_q ^ ACTIVE_LOW_IN;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= REL_STABLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      REL_STABLE: begin
        if (lvl) begin
          state_d = PRESS_CHECK;
          cnt_d   = ONE;
        end
      end
      PRESS_CHECK: begin
        if (!lvl) begin
          state_d = REL_STABLE;
        end else if (cnt_q == LAST) begin
          state_d = PRS_STABLE;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PRS_STABLE: begin
        if (!lvl) begin
          state_d = REL_CHECK;
          cnt_d   = ONE;
        end
      end
      REL_CHECK: begin
        if (lvl) begin
          state_d = PRS_STABLE;
        end else if (cnt_q == LAST) begin
          state_d = REL_STABLE;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = REL_STABLE;
      end
    endcase
  end

  // The clean level is a pure decode of the state so it drops with reset.
  assign key_o         = (state_q == PRS_STABLE) || (state_q == REL_CHECK);
  assign key_press_o   = press_q;
  assign key_release_o = rel_q;

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel push-button conditioner: WIDTH independent debounce channels.
module key_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 16,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    key_debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW_IN(ACTIVE_LOW_IN)
    ) u_chan (
      .Clock        (Clock),
      .Reset        (Reset),
      .key_raw_i    (key_raw[g]),
      .key_o        (key[g]),
      .key_press_o  (key_press[g]),
      .key_release_o(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised and directed bench for key_debouncer against a sliding-window model.
module tb_key_debouncer;

  localparam int W = 2;
  localparam int S = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] key_raw = 2'b11;
  logic [W-1:0] key, key_press, key_release;

  always #5 Clock = ~Clock;

  key_debouncer #(
    .WIDTH(W), .STABLE_CYCLES(S), .ACTIVE_LOW_IN(1'b1)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .key_raw    (key_raw),
    .key        (key),
    .key_press  (key_press),
    .key_release(key_release)
  );

  int total = 0;
  int bad   = 0;

  // Model: pressed-level samples per edge; the clean level flips when the
  // last S synchronised samples all disagree with it.
  logic [W-1:0] samp_q[$];
  logic [W-1:0] sync_q[$];
  logic [W-1:0] mkey, mpress, mrel;
  int           pcnt0, rcnt0;
  bit           both_press, both_rel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    samp_q.delete();
    sync_q.delete();
    mkey   = '0;
    mpress = '0;
    mrel   = '0;
  endtask

  task automatic tick();
    logic [W-1:0] sy;
    bit           all_diff;
    @(posedge Clock);
    sy = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : '0;
    samp_q.push_back(~key_raw);
    sync_q.push_back(sy);
    if (samp_q.size() > S + 4) void'(samp_q.pop_front());
    if (sync_q.size() > S + 4) void'(sync_q.pop_front());
    mpress = '0;
    mrel   = '0;
    for (int ch = 0; ch < W; ch++) begin
      if (sync_q.size() >= S) begin
        all_diff = 1'b1;
        for (int j = 0; j < S; j++)
          if (sync_q[sync_q.size()-1-j][ch] == mkey[ch]) all_diff = 1'b0;
        if (all_diff) begin
          mkey[ch] = ~mkey[ch];
          if (mkey[ch]) mpress[ch] = 1'b1;
          else          mrel[ch]   = 1'b1;
        end
      end
    end
    #1;
    chk("key", 32'(key), 32'(mkey));
    chk("key_press", 32'(key_press), 32'(mpress));
    chk("key_release", 32'(key_release), 32'(mrel));
    if (key_press[0])      pcnt0++;
    if (key_release[0])    rcnt0++;
    if (key_press == 2'b11)   both_press = 1'b1;
    if (key_release == 2'b11) both_rel   = 1'b1;
  endtask

  task automatic run(input logic [W-1:0] val, input int n);
    key_raw = val;
    repeat (n) tick();
  endtask

  // Ticks until key[ch] reads target; returns tick count, or 20 on timeout.
  task automatic lat(input int ch, input logic target, output int n);
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (key[ch] == target) break;
    end
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear at once.
  task automatic reset_pulse(input logic [W-1:0] raw_during, input int hold);
    #2;
    key_raw = raw_during;
    Reset   = 1'b0;
    #1;
    chk("rst_async", {29'd0, key, key_press[0], key_release[0]}, 32'd0);
    repeat (hold) begin
      @(posedge Clock);
      #1;
      chk("rst_hold", {26'd0, key, key_press, key_release}, 32'd0);
    end
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    model_reset();
    pcnt0 = 0; rcnt0 = 0; both_press = 0; both_rel = 0;

    // Reset held with pins reading pressed.
    #2;
    key_raw = 2'b00;
    Reset   = 1'b0;
    #1;
    chk("rst_initial", {26'd0, key, key_press, key_release}, 32'd0);
    repeat (4) begin
      @(posedge Clock);
      #1;
      chk("rst_hold0", {26'd0, key, key_press, key_release}, 32'd0);
    end
    key_raw = 2'b11;
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
    run(2'b11, 6);

    // Clean press of channel 0: key visible after the sixth edge.
    pcnt0 = 0;
    key_raw = 2'b10;
    lat(0, 1'b1, n);
    chk("press_latency", 32'(n), 32'd6);
    run(2'b10, 6);
    chk("press_once", 32'(pcnt0), 32'd1);
    chk("key_held", 32'(key), 32'd1);

    // Release, then a short glitch that must be rejected.
    run(2'b11, 10);
    pcnt0 = 0;
    run(2'b10, 3);
    run(2'b11, 10);
    chk("glitch_key", 32'(key), 32'd0);
    chk("glitch_press", 32'(pcnt0), 32'd0);

    // Bounce then steady press: one strobe, S+1 edges after final capture.
    pcnt0 = 0;
    run(2'b10, 2); run(2'b11, 1); run(2'b10, 2); run(2'b11, 1);
    key_raw = 2'b10;
    lat(0, 1'b1, n);
    chk("bounce_latency", 32'(n), 32'd6);
    run(2'b10, 4);
    chk("bounce_press", 32'(pcnt0), 32'd1);
    run(2'b11, 10);

    // Both channels together.
    both_press = 0; both_rel = 0;
    run(2'b00, 20);
    run(2'b11, 20);
    chk("both_press", 32'(both_press), 32'd1);
    chk("both_release", 32'(both_rel), 32'd1);

    // Reset during a release check: no release strobe, fresh press after.
    run(2'b10, 10);
    rcnt0 = 0;
    run(2'b11, 4);
    reset_pulse(2'b10, 3);
    pcnt0 = 0;
    lat(0, 1'b1, n);
    chk("rst_repress_latency", 32'(n), 32'd6);
    run(2'b10, 3);
    chk("rst_no_release", 32'(rcnt0), 32'd0);
    chk("rst_repress_once", 32'(pcnt0), 32'd1);

    // Random segments, mostly short enough to bounce, with occasional resets.
    repeat (300) begin
      run(W'($urandom_range(0, 3)), $urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) reset_pulse(W'($urandom_range(0, 3)), $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
